// File: rtl/load_response_aligner_if.sv
// ----------------------------------------------------------------------------
// load_response_aligner_if
// Bundles the signals between the load-response aligner and its neighbours:
// the load-attribute FIFO head, the memory read-response stream and the
// writeback output.
//
//   attr_valid      head of the attribute FIFO is valid
//   attr_fn3        load type of the head entry (LB/LH/LW/LBU/LHU)
//   attr_byte_addr  low two address bits of the head entry
//   attr_id         writeback ID of the head entry
//   attr_pop        one-cycle pulse that consumes the head entry
//   rd_valid        memory read response present (cannot be stalled)
//   rd_data         raw aligned word from memory
//   resp_full       response buffer is full
//   wb_valid        writeback result valid
//   wb_ack          writeback consumer accepts the result
//   wb_data         extracted and extended load result
//   wb_id           writeback ID of the result
//
// The master modport is the environment side; the slave modport is the
// aligner.
// ----------------------------------------------------------------------------
interface load_response_aligner_if #(
    parameter int ID_WIDTH = 3
);
    logic                attr_valid;
    logic [2:0]          attr_fn3;
    logic [1:0]          attr_byte_addr;
    logic [ID_WIDTH-1:0] attr_id;
    logic                attr_pop;
    logic                rd_valid;
    logic [31:0]         rd_data;
    logic                resp_full;
    logic                wb_valid;
    logic                wb_ack;
    logic [31:0]         wb_data;
    logic [ID_WIDTH-1:0] wb_id;

    modport master (
        output attr_valid, attr_fn3, attr_byte_addr, attr_id,
        output rd_valid, rd_data, wb_ack,
        input  attr_pop, resp_full, wb_valid, wb_data, wb_id
    );

    modport slave (
        input  attr_valid, attr_fn3, attr_byte_addr, attr_id,
        input  rd_valid, rd_data, wb_ack,
        output attr_pop, resp_full, wb_valid, wb_data, wb_id
    );
endinterface

// File: rtl/load_response_aligner.sv
// ----------------------------------------------------------------------------
// load_response_aligner
// Pairs memory read responses with the load attributes that requested them
// and produces sign/zero-extended writeback results.
//
// Responses are pushed into a small in-order buffer (no bypass). When the
// buffer holds a word, the attribute FIFO head is valid and the output
// register is free (empty or being acknowledged), the head word and head
// attribute are consumed together and the extracted result is registered.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - load_response_aligner_if.slave (attribute head, read response,
//          writeback handshake)
//
// Parameters:
//   ID_WIDTH   - writeback ID width
//   RESP_DEPTH - response buffer entries, 2 or 4
// ----------------------------------------------------------------------------
module load_response_aligner #(
    parameter int ID_WIDTH   = 3,
    parameter int RESP_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    load_response_aligner_if.slave  bus
);

    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(RESP_DEPTH);

    typedef enum logic [2:0] {
        FN3_LB  = 3'b000,
        FN3_LH  = 3'b001,
        FN3_LW  = 3'b010,
        FN3_LBU = 3'b100,
        FN3_LHU = 3'b101
    } load_fn3_e;

    generate
        if ((RESP_DEPTH != 2) && (RESP_DEPTH != 4)) begin : g_bad_depth
            $error("load_response_aligner: RESP_DEPTH must be 2 or 4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response buffer state
    // ------------------------------------------------------------------
    logic [31:0]         r_buf [RESP_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    // Writeback output register
    logic                r_wb_valid;
    logic [31:0]         r_wb_data;
    logic [ID_WIDTH-1:0] r_wb_id;

    logic                w_empty;
    logic                w_full;
    logic                w_out_free;
    logic                w_fire;
    logic                w_push;
    logic [31:0]         w_head;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_result;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_COUNT);
    assign w_out_free = ~r_wb_valid | bus.wb_ack;
    assign w_fire     = ~w_empty & bus.attr_valid & w_out_free;

    // A push into a full buffer is only accepted when the head leaves in
    // the same cycle; otherwise it is dropped so stored words stay intact.
    assign w_push     = bus.rd_valid & (~w_full | w_fire);

    assign w_head     = r_buf[r_rd_ptr];

    // ------------------------------------------------------------------
    // Extraction: byte lane picked by the full byte address, half lane by
    // bit 1 only (misaligned halfwords are not corrected).
    // ------------------------------------------------------------------
    assign w_byte = w_head[{bus.attr_byte_addr, 3'b000} +: 8];
    assign w_half = w_head[{bus.attr_byte_addr[1], 4'b0000} +: 16];

    // NOTE: the default assignment before the case keeps this purely
    // combinational; a missing path here would infer a latch.
    always_comb begin
        w_load_result = w_head;
        case (bus.attr_fn3)
            FN3_LB:  w_load_result = {{24{w_byte[7]}}, w_byte};
            FN3_LBU: w_load_result = {24'h000000, w_byte};
            FN3_LH:  w_load_result = {{16{w_half[15]}}, w_half};
            FN3_LHU: w_load_result = {16'h0000, w_half};
            FN3_LW:  w_load_result = w_head;
            default: w_load_result = w_head;
        endcase
    end

    // ------------------------------------------------------------------
    // Buffer storage
    // NOTE: the data array carries no reset; emptiness is tracked by the
    // count, so stale words are never observed and the array can map to
    // plain flops or RAM without a reset network.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= bus.rd_data;
        end
    end

    // Pointers wrap naturally because RESP_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_fire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Writeback register: loads on fire, clears on acknowledge, holds
    // otherwise so data/ID stay stable while the consumer stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_id    <= '0;
        end else if (w_fire) begin
            r_wb_valid <= 1'b1;
            r_wb_data  <= w_load_result;
            r_wb_id    <= bus.attr_id;
        end else if (bus.wb_ack) begin
            r_wb_valid <= 1'b0;
        end
    end

    assign bus.attr_pop  = w_fire;
    assign bus.resp_full = w_full;
    assign bus.wb_valid  = r_wb_valid;
    assign bus.wb_data   = r_wb_data;
    assign bus.wb_id     = r_wb_id;

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst)
        !(bus.rd_valid && w_full && !w_fire)
    );

    a_no_attr_underflow: assert property (
        @(posedge clk) disable iff (!rst)
        bus.attr_pop |-> bus.attr_valid
    );

endmodule

// File: tb/tb_load_response_aligner.sv
// ----------------------------------------------------------------------------
// tb_load_response_aligner
// Directed vectors for extraction, hand-written sequences for back-pressure,
// buffered-before-attribute and mid-operation reset, then a randomised run
// against a small behavioural model.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_load_response_aligner;

    localparam int ID_W  = 3;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    load_response_aligner_if #(.ID_WIDTH(ID_W)) bus ();

    load_response_aligner #(
        .ID_WIDTH  (ID_W),
        .RESP_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0]     word;
        logic [2:0]      fn3;
        logic [1:0]      addr;
        logic [ID_W-1:0] id;
        logic [31:0]     exp;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Independent reference for extraction using shifts and masks.
    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [2:0] fn3,
                                            input logic [1:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (32'(a) * 8)) & 32'h0000_00FF;
        h = (w >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (fn3)
            3'd0:    ref_ext = b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd4:    ref_ext = b;
            3'd1:    ref_ext = h[15] ? (h | 32'hFFFF_0000) : h;
            3'd5:    ref_ext = h;
            default: ref_ext = w;
        endcase
    endfunction

    // Random-run model state
    logic [31:0]     q [$];
    logic            m_valid;
    logic [31:0]     m_data;
    logic [ID_W-1:0] m_id;
    logic [2:0]      h_fn3;
    logic [1:0]      h_addr;
    logic [ID_W-1:0] h_id;
    logic            exp_pop;

    initial begin
        bus.attr_valid     = 1'b0;
        bus.attr_fn3       = 3'b010;
        bus.attr_byte_addr = 2'd0;
        bus.attr_id        = '0;
        bus.rd_valid       = 1'b0;
        bus.rd_data        = '0;
        bus.wb_ack         = 1'b0;

        vecs[0]  = '{32'h8899AABB, 3'b000, 2'd2, 3'd1, 32'hFFFFFF99};
        vecs[1]  = '{32'h8899AABB, 3'b101, 2'd3, 3'd2, 32'h00008899};
        vecs[2]  = '{32'h8899AABB, 3'b001, 2'd0, 3'd3, 32'hFFFFAABB};
        vecs[3]  = '{32'h8899AABB, 3'b100, 2'd3, 3'd4, 32'h00000088};
        vecs[4]  = '{32'h8899AABB, 3'b000, 2'd0, 3'd5, 32'hFFFFFFBB};
        vecs[5]  = '{32'h8899AABB, 3'b100, 2'd1, 3'd6, 32'h000000AA};
        vecs[6]  = '{32'h8899AABB, 3'b001, 2'd1, 3'd7, 32'hFFFFAABB};
        vecs[7]  = '{32'h8899AABB, 3'b101, 2'd2, 3'd0, 32'h00008899};
        vecs[8]  = '{32'h8899AABB, 3'b010, 2'd1, 3'd1, 32'h8899AABB};
        vecs[9]  = '{32'h8899AABB, 3'b011, 2'd2, 3'd2, 32'h8899AABB};
        vecs[10] = '{32'h8899AABB, 3'b110, 2'd3, 3'd3, 32'h8899AABB};
        vecs[11] = '{32'h8899AABB, 3'b111, 2'd0, 3'd4, 32'h8899AABB};
        vecs[12] = '{32'h1234567F, 3'b000, 2'd0, 3'd5, 32'h0000007F};
        vecs[13] = '{32'h12347FFF, 3'b001, 2'd0, 3'd6, 32'h00007FFF};
        vecs[14] = '{32'h00000080, 3'b000, 2'd0, 3'd7, 32'hFFFFFF80};

        // ---------------- reset state ----------------
        #2 rst = 1'b0;
        bus.attr_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid",  32'(bus.wb_valid),  32'd0);
        check("rst_wb_data",   bus.wb_data,        32'd0);
        check("rst_wb_id",     32'(bus.wb_id),     32'd0);
        check("rst_attr_pop",  32'(bus.attr_pop),  32'd0);
        check("rst_resp_full", 32'(bus.resp_full), 32'd0);
        rst = 1'b1;
        bus.attr_valid = 1'b0;

        // ---------------- extraction table ----------------
        for (int i = 0; i < NVEC; i++) begin
            tick();
            bus.rd_valid       = 1'b1;
            bus.rd_data        = vecs[i].word;
            bus.attr_valid     = 1'b1;
            bus.attr_fn3       = vecs[i].fn3;
            bus.attr_byte_addr = vecs[i].addr;
            bus.attr_id        = vecs[i].id;
            bus.wb_ack         = 1'b1;
            sample();
            check($sformatf("v%0d_pop_n0", i), 32'(bus.attr_pop), 32'd0);
            tick();
            bus.rd_valid = 1'b0;
            sample();
            check($sformatf("v%0d_pop_n1", i), 32'(bus.attr_pop), 32'd1);
            check($sformatf("v%0d_valid_n1", i), 32'(bus.wb_valid), 32'd0);
            tick();
            bus.attr_valid = 1'b0;
            sample();
            check($sformatf("v%0d_valid_n2", i), 32'(bus.wb_valid), 32'd1);
            check($sformatf("v%0d_data", i), bus.wb_data, vecs[i].exp);
            check($sformatf("v%0d_id", i), 32'(bus.wb_id), 32'(vecs[i].id));
            tick();
            sample();
            check($sformatf("v%0d_valid_n3", i), 32'(bus.wb_valid), 32'd0);
        end

        // ---------------- back-pressure with full buffer ----------------
        tick();
        bus.attr_valid = 1'b1; bus.attr_fn3 = 3'b010; bus.attr_byte_addr = 2'd0;
        bus.attr_id = 3'd1; bus.wb_ack = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_data = 32'h1111_1111;
        sample();
        check("bp_c1_pop", 32'(bus.attr_pop), 32'd0);
        tick();
        bus.rd_data = 32'h2222_2222;
        sample();
        check("bp_c2_pop", 32'(bus.attr_pop), 32'd1);
        tick();
        bus.attr_id = 3'd2; bus.rd_data = 32'h3333_3333;
        sample();
        check("bp_c3_pop",  32'(bus.attr_pop),  32'd0);
        check("bp_c3_full", 32'(bus.resp_full), 32'd0);
        check("bp_c3_data", bus.wb_data, 32'h1111_1111);
        for (int c = 0; c < 3; c++) begin
            tick();
            bus.rd_valid = 1'b0;
            sample();
            check($sformatf("bp_hold%0d_full", c),  32'(bus.resp_full), 32'd1);
            check($sformatf("bp_hold%0d_valid", c), 32'(bus.wb_valid),  32'd1);
            check($sformatf("bp_hold%0d_data", c),  bus.wb_data,         32'h1111_1111);
            check($sformatf("bp_hold%0d_id", c),    32'(bus.wb_id),      32'd1);
            check($sformatf("bp_hold%0d_pop", c),   32'(bus.attr_pop),   32'd0);
        end
        tick();
        bus.wb_ack = 1'b1;
        sample();
        check("bp_r1_pop",  32'(bus.attr_pop), 32'd1);
        check("bp_r1_data", bus.wb_data,       32'h1111_1111);
        tick();
        bus.attr_id = 3'd3;
        sample();
        check("bp_r2_pop",  32'(bus.attr_pop),  32'd1);
        check("bp_r2_full", 32'(bus.resp_full), 32'd0);
        check("bp_r2_data", bus.wb_data,        32'h2222_2222);
        check("bp_r2_id",   32'(bus.wb_id),     32'd2);
        tick();
        bus.attr_valid = 1'b0;
        sample();
        check("bp_r3_pop",  32'(bus.attr_pop), 32'd0);
        check("bp_r3_data", bus.wb_data,       32'h3333_3333);
        check("bp_r3_id",   32'(bus.wb_id),    32'd3);
        tick();
        sample();
        check("bp_end_valid", 32'(bus.wb_valid), 32'd0);

        // ---------------- responses before attributes ----------------
        tick();
        bus.rd_valid = 1'b1; bus.rd_data = 32'hAAAA_0005;
        sample();
        check("ba_c1_pop", 32'(bus.attr_pop), 32'd0);
        tick();
        bus.rd_data = 32'hBBBB_0006;
        sample();
        check("ba_c2_pop", 32'(bus.attr_pop), 32'd0);
        tick();
        bus.rd_valid = 1'b0;
        sample();
        check("ba_c3_full",  32'(bus.resp_full), 32'd1);
        check("ba_c3_pop",   32'(bus.attr_pop),  32'd0);
        check("ba_c3_valid", 32'(bus.wb_valid),  32'd0);
        tick();
        bus.attr_valid = 1'b1; bus.attr_id = 3'd5;
        sample();
        check("ba_c4_pop", 32'(bus.attr_pop), 32'd1);
        tick();
        bus.attr_id = 3'd6;
        sample();
        check("ba_c5_pop",  32'(bus.attr_pop), 32'd1);
        check("ba_c5_id",   32'(bus.wb_id),    32'd5);
        check("ba_c5_data", bus.wb_data,       32'hAAAA_0005);
        tick();
        bus.attr_valid = 1'b0;
        sample();
        check("ba_c6_valid", 32'(bus.wb_valid), 32'd1);
        check("ba_c6_id",    32'(bus.wb_id),    32'd6);
        check("ba_c6_data",  bus.wb_data,       32'hBBBB_0006);
        tick();
        sample();
        check("ba_c7_valid", 32'(bus.wb_valid), 32'd0);

        // ---------------- reset mid-operation ----------------
        tick();
        bus.wb_ack = 1'b0; bus.attr_valid = 1'b1; bus.attr_id = 3'd2;
        bus.rd_valid = 1'b1; bus.rd_data = 32'hC0DE_0001;
        tick();
        bus.rd_data = 32'hC0DE_0002;
        tick();
        bus.rd_valid = 1'b0; bus.attr_valid = 1'b0;
        sample();
        check("mr_pre_valid", 32'(bus.wb_valid), 32'd1);
        bus.wb_ack = 1'b1; bus.attr_valid = 1'b1;
        #1;
        check("mr_pre_pop", 32'(bus.attr_pop), 32'd1);
        rst = 1'b0;
        #1;
        check("mr_valid", 32'(bus.wb_valid),  32'd0);
        check("mr_full",  32'(bus.resp_full), 32'd0);
        check("mr_pop",   32'(bus.attr_pop),  32'd0);
        check("mr_data",  bus.wb_data,        32'd0);
        check("mr_id",    32'(bus.wb_id),     32'd0);
        tick();
        rst = 1'b1;
        bus.rd_valid = 1'b1; bus.rd_data = 32'h1234_5678;
        bus.attr_fn3 = 3'b000; bus.attr_byte_addr = 2'd0; bus.attr_id = 3'd4;
        sample();
        check("mr_r0_pop",   32'(bus.attr_pop), 32'd0);
        check("mr_r0_valid", 32'(bus.wb_valid), 32'd0);
        tick();
        bus.rd_valid = 1'b0;
        sample();
        check("mr_r1_pop",   32'(bus.attr_pop), 32'd1);
        check("mr_r1_valid", 32'(bus.wb_valid), 32'd0);
        tick();
        bus.attr_valid = 1'b0;
        sample();
        check("mr_r2_valid", 32'(bus.wb_valid), 32'd1);
        check("mr_r2_data",  bus.wb_data,       32'h0000_0078);
        check("mr_r2_id",    32'(bus.wb_id),    32'd4);
        tick();
        sample();
        check("mr_r3_valid", 32'(bus.wb_valid), 32'd0);

        // ---------------- random run against the model ----------------
        m_valid = 1'b0; m_data = '0; m_id = '0;
        h_fn3  = 3'($urandom_range(0, 7));
        h_addr = 2'($urandom_range(0, 3));
        h_id   = ID_W'($urandom_range(0, 7));
        for (int i = 0; i < 10000; i++) begin
            tick();
            bus.wb_ack         = ($urandom_range(0, 3) != 0);
            bus.attr_valid     = ($urandom_range(0, 1) != 0);
            bus.attr_fn3       = h_fn3;
            bus.attr_byte_addr = h_addr;
            bus.attr_id        = h_id;
            bus.rd_valid       = (q.size() < DEPTH) && ($urandom_range(0, 1) != 0);
            bus.rd_data        = $urandom;
            sample();
            exp_pop = (q.size() > 0) && bus.attr_valid && (!m_valid || bus.wb_ack);
            check("rnd_pop",   32'(bus.attr_pop),  32'(exp_pop));
            check("rnd_full",  32'(bus.resp_full), 32'(q.size() == DEPTH));
            check("rnd_valid", 32'(bus.wb_valid),  32'(m_valid));
            if (m_valid) begin
                check("rnd_data", bus.wb_data,    m_data);
                check("rnd_id",   32'(bus.wb_id), 32'(m_id));
            end
            if (exp_pop) begin
                m_valid = 1'b1;
                m_data  = ref_ext(q[0], h_fn3, h_addr);
                m_id    = h_id;
                void'(q.pop_front());
                h_fn3  = 3'($urandom_range(0, 7));
                h_addr = 2'($urandom_range(0, 3));
                h_id   = ID_W'($urandom_range(0, 7));
            end else if (bus.wb_ack) begin
                m_valid = 1'b0;
            end
            if (bus.rd_valid) begin
                q.push_back(bus.rd_data);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_response_aligner.md
LOAD_RESPONSE_ALIGNER -- requirements
Module: load_response_aligner

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 3, the width of the load writeback ID.
REQ-002 The block SHALL have parameter RESP_DEPTH, default 2, the number of memory response buffer entries; the only legal values are 2 and 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port attr_valid, input, 1 bit: the head of the load-attribute FIFO is valid.
REQ-006 The block SHALL have port attr_fn3, input, 3 bits: the load type of the head attribute entry.
REQ-007 The block SHALL have port attr_byte_addr, input, 2 bits: the low address bits of the head attribute entry.
REQ-008 The block SHALL have port attr_id, input, ID_WIDTH bits: the writeback ID of the head attribute entry.
REQ-009 The block SHALL have port attr_pop, output, 1 bit: a one-cycle pulse that consumes the head attribute entry.
REQ-010 The block SHALL have port rd_valid, input, 1 bit: a memory read response is present this cycle; it cannot be stalled.
REQ-011 The block SHALL have port rd_data, input, 32 bits: the raw aligned word from memory.
REQ-012 The block SHALL have port resp_full, output, 1 bit: the response buffer holds RESP_DEPTH entries; the issue logic SHALL NOT send a request that could return while this is high.
REQ-013 The block SHALL have port wb_valid, output, 1 bit: the writeback result is valid.
REQ-014 The block SHALL have port wb_ack, input, 1 bit: the writeback consumer accepts the result.
REQ-015 The block SHALL have port wb_data, output, 32 bits: the extracted and extended load result.
REQ-016 The block SHALL have port wb_id, output, ID_WIDTH bits: the ID of the result.

Function
REQ-017 The response buffer SHALL be an in-order FIFO with a count of width $clog2(RESP_DEPTH)+1; rd_valid pushes rd_data into it.
REQ-018 A simultaneous push and pop on the buffer SHALL leave the count unchanged; the read and write pointers SHALL wrap modulo RESP_DEPTH.
REQ-019 A push when full and not popping SHALL be an error, caught by an assertion; the data that was already stored SHALL remain unaltered.
REQ-020 Signal out_free SHALL be defined as ~wb_valid | wb_ack.
REQ-021 Signal fire SHALL be defined as (buffer non-empty) & attr_valid & out_free.
REQ-022 On fire, attr_pop SHALL be 1 and the buffer SHALL pop in the same cycle; in all other cycles attr_pop SHALL be 0.
REQ-023 The buffer SHALL have no bypass: the minimum latency from rd_valid to wb_valid SHALL be 2 cycles (push at cycle N, fire at N+1, wb_valid at N+2).
REQ-024 On fire, wb_valid SHALL be set to 1 and wb_data and wb_id SHALL be loaded at the next edge.
REQ-025 When wb_ack=1 and there is no fire, wb_valid SHALL clear at the next edge.
REQ-026 While wb_valid=1 and wb_ack=0, wb_data and wb_id SHALL hold stable.
REQ-027 Back-to-back fires SHALL give one result per cycle while wb_ack is held at 1.
REQ-028 Extraction: byte = head word bits [8*attr_byte_addr +: 8]; half = bits [16*attr_byte_addr[1] +: 16]; attr_byte_addr[0] SHALL be ignored for halfword loads (no misalignment correction).
REQ-029 attr_fn3 000 (LB) SHALL sign-extend the byte; 100 (LBU) SHALL zero-extend the byte.
REQ-030 attr_fn3 001 (LH) SHALL sign-extend the half; 101 (LHU) SHALL zero-extend the half.
REQ-031 attr_fn3 010 (LW) and every other encoding SHALL pass the full word.
REQ-032 attr_pop SHALL be asserted only in a cycle where attr_valid=1 (no underflow), checked by an assertion.
REQ-033 A response arriving while attr_valid=0 SHALL wait in the buffer; no attribute entry SHALL be consumed without data.

Reset
REQ-034 While rst=0, asynchronously: buffer count=0, pointers=0, wb_valid=0, attr_pop=0, resp_full=0.
REQ-035 While rst=0, wb_data and wb_id SHALL be 0.
REQ-036 A reset in the middle of operation SHALL discard all buffered responses and any pending result; the first fire SHALL be possible 1 cycle after rst rises, once a new response has arrived.
REQ-037 Assertions SHALL be disabled while rst=0.

Verification
REQ-038 Scenario: rd_data=0x8899AABB, LB, byte_addr=2, wb_ack=1 -> wb_data=0xFFFFFF99 2 cycles after rd_valid; attr_pop pulses once.
REQ-039 Scenario: same word with LHU, byte_addr=3 -> wb_data=0x00008899; LH with byte_addr=0 -> wb_data=0xFFFFAABB.
REQ-040 Scenario: wb_ack=0 with 3 responses (RESP_DEPTH=2) issued while resp_full is respected -> first result held stable with its ID; resp_full=1 after the 2nd buffered response; all 3 results delivered in order when wb_ack=1.
REQ-041 Scenario: 2 responses arrive while attr_valid=0, then attr_valid=1 with IDs 5 and 6 -> results appear with wb_id 5 then 6 on consecutive cycles.
REQ-042 Scenario: rst driven to 0 with 1 buffered response and wb_valid=1 -> wb_valid=0 and resp_full=0 immediately; no stale result appears after reset releases.
REQ-043 Scenario: random rd_valid, attr_valid and wb_ack stimulus compared against a reference model over 10k cycles -> zero mismatches and no assertion failures.
